// File: rtl/axi4r_chk_buffer_pkg.sv
// -----------------------------------------------------------------------------
// axi4r_chk_buffer_pkg
// Shared types and constants for the AXI4 read-data buffer and burst checker.
//   AXI_DATA_W / AXI_ID_W / AXI_LEN_W : default R-channel field widths
//   RESP_*                            : RRESP encodings
//   axi4r_beat_t                      : one R beat {id, data, resp, last}
// -----------------------------------------------------------------------------
package axi4r_chk_buffer_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 1;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi4r_beat_t;

endpackage

// File: rtl/axi4r_chk_buffer_if.sv
// -----------------------------------------------------------------------------
// axi4r_chk_buffer_if
// Bundles the AR observation signals, the slave-side R channel (s_r*) and the
// master-side R channel (m_r*) around the buffer.
//   modport slave  : the buffer's view (accepts AR/s_r*, drives m_r*)
//   modport master : the environment's view (drives AR/s_r*, consumes m_r*)
// -----------------------------------------------------------------------------
interface axi4r_chk_buffer_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
);

  logic              ar_valid;
  logic              ar_ready;
  logic [LEN_W-1:0]  ar_len;

  logic [ID_W-1:0]   s_rid;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready;

  logic [ID_W-1:0]   m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport slave (
    input  ar_valid, ar_len,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  m_rready,
    output ar_ready, s_rready,
    output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport master (
    output ar_valid, ar_len,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output m_rready,
    input  ar_ready, s_rready,
    input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );

endinterface

// File: rtl/axi4r_chk_buffer_sync_fifo.sv
// -----------------------------------------------------------------------------
// axi4r_chk_buffer_sync_fifo
// Pointer + occupancy-count synchronous FIFO. full/empty come straight from the
// registered count, so there is no combinational path from pop to full.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request (ignored when full)
//   pop        : read request (ignored when empty)
//   rdata      : head entry (zero after reset)
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module axi4r_chk_buffer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == (AW+1)'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage array; cleared on reset so the head reads as zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi4r_chk_buffer.sv
// -----------------------------------------------------------------------------
// axi4r_chk_buffer
// AXI4 R-channel buffer with burst-length checking. R beats from the slave are
// stored in a DEPTH-entry FIFO and forwarded unchanged to the master one cycle
// after acceptance. Every accepted AR length is queued (OUTST entries); each
// accepted R beat is checked against the head length and sticky error flags
// record early RLAST, missing RLAST and beats arriving with no burst pending.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : AR observation + s_r* input channel + m_r* output channel
//   err_clr     : clears all sticky error flags (wins over a same-cycle error)
//   err_early   : RLAST seen before beat len+1
//   err_miss    : beat len+1 seen without RLAST
//   err_unexp   : R beat accepted while no burst length was queued
//   beat_cnt    : beats accepted so far in the current burst
// -----------------------------------------------------------------------------
module axi4r_chk_buffer
  import axi4r_chk_buffer_pkg::*;
#(
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W,
  parameter int LEN_W  = AXI_LEN_W,
  parameter int DEPTH  = 4,
  parameter int OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4r_chk_buffer_if.slave     bus,
  input  logic                  err_clr,
  output logic                  err_early,
  output logic                  err_miss,
  output logic                  err_unexp,
  output logic [LEN_W-1:0]      beat_cnt
);

  localparam int BEAT_W = ID_W + DATA_W + 3;

  logic [BEAT_W-1:0] beat_in_s;
  logic [BEAT_W-1:0] beat_out_s;
  logic              beat_full_s;
  logic              beat_empty_s;
  logic              beat_push_s;
  logic              beat_pop_s;

  logic [LEN_W-1:0]  len_head_s;
  logic              len_full_s;
  logic              len_empty_s;
  logic              len_push_s;
  logic              len_pop_s;

  logic [LEN_W-1:0]  beat_cnt_r;
  logic [LEN_W-1:0]  cnt_nxt_s;
  logic              early_evt_s;
  logic              miss_evt_s;
  logic              unexp_evt_s;
  logic              err_early_r;
  logic              err_miss_r;
  logic              err_unexp_r;

  // ---------------- handshake glue ----------------
  assign beat_in_s   = {bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast};
  assign bus.s_rready = !beat_full_s;
  assign beat_push_s = bus.s_rvalid && !beat_full_s;
  assign beat_pop_s  = !beat_empty_s && bus.m_rready;

  assign {bus.m_rid, bus.m_rdata, bus.m_rresp, bus.m_rlast} = beat_out_s;
  assign bus.m_rvalid = !beat_empty_s;

  assign bus.ar_ready = !len_full_s;
  assign len_push_s   = bus.ar_valid && !len_full_s;

  axi4r_chk_buffer_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_beat_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (beat_push_s),
    .wdata (beat_in_s),
    .pop   (beat_pop_s),
    .rdata (beat_out_s),
    .full  (beat_full_s),
    .empty (beat_empty_s)
  );

  axi4r_chk_buffer_sync_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (OUTST)
  ) u_len_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (len_push_s),
    .wdata (bus.ar_len),
    .pop   (len_pop_s),
    .rdata (len_head_s),
    .full  (len_full_s),
    .empty (len_empty_s)
  );

  // ---------------- burst checker ----------------
  // Classify each accepted beat against the head length. The length queue's
  // empty flag is registered, so an AR accepted this very cycle is not yet
  // visible to a same-cycle beat.
  always_comb begin
    cnt_nxt_s   = beat_cnt_r;
    len_pop_s   = 1'b0;
    early_evt_s = 1'b0;
    miss_evt_s  = 1'b0;
    unexp_evt_s = 1'b0;
    if (beat_push_s) begin
      if (len_empty_s) begin
        unexp_evt_s = 1'b1;
      end else if (beat_cnt_r < len_head_s) begin
        if (bus.s_rlast) begin
          early_evt_s = 1'b1;
          len_pop_s   = 1'b1;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = beat_cnt_r + LEN_W'(1);
        end
      end else begin
        // Final expected beat: burst ends either way, flag if RLAST is absent.
        len_pop_s  = 1'b1;
        cnt_nxt_s  = '0;
        miss_evt_s = !bus.s_rlast;
      end
    end else begin
      cnt_nxt_s = beat_cnt_r;
    end
  end

  // Beat counter within the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= '0;
    end else begin
      beat_cnt_r <= cnt_nxt_s;
    end
  end

  // Sticky error flags; a clear request discards any same-cycle new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_early_r <= 1'b0;
      err_miss_r  <= 1'b0;
      err_unexp_r <= 1'b0;
    end else if (err_clr) begin
      err_early_r <= 1'b0;
      err_miss_r  <= 1'b0;
      err_unexp_r <= 1'b0;
    end else begin
      err_early_r <= err_early_r | early_evt_s;
      err_miss_r  <= err_miss_r  | miss_evt_s;
      err_unexp_r <= err_unexp_r | unexp_evt_s;
    end
  end

  assign err_early = err_early_r;
  assign err_miss  = err_miss_r;
  assign err_unexp = err_unexp_r;
  assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_axi4r_chk_buffer.sv
// -----------------------------------------------------------------------------
// tb_axi4r_chk_buffer
// Self-checking bench for axi4r_chk_buffer: directed scenarios followed by
// random traffic. A reference model (queues of expected beats and burst
// lengths) is updated from the stimulus; a negedge monitor compares the DUT.
// -----------------------------------------------------------------------------
module tb_axi4r_chk_buffer;
  import axi4r_chk_buffer_pkg::*;

  localparam int DATA_W = 64;
  localparam int ID_W   = 1;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 4;
  localparam int OUTST  = 4;

  logic clk;
  logic rst_n;
  logic err_clr;
  logic err_early;
  logic err_miss;
  logic err_unexp;
  logic [LEN_W-1:0] beat_cnt;

  axi4r_chk_buffer_if #(.DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  axi4r_chk_buffer #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .LEN_W  (LEN_W),
    .DEPTH  (DEPTH),
    .OUTST  (OUTST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_early (err_early),
    .err_miss  (err_miss),
    .err_unexp (err_unexp),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  axi4r_beat_t exp_q[$];
  int          len_q[$];
  int          m_cnt;
  bit          m_early;
  bit          m_miss;
  bit          m_unexp;

  logic [1:0] resp_tab [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model: compare state produced by the previous edge, then
  // fold in the handshakes that the coming edge will perform.
  always @(negedge clk) begin : monitor
    int sz;
    int lsz;
    int len;
    bit e_early;
    bit e_miss;
    bit e_unexp;
    axi4r_beat_t b;
    if (!rst_n) begin
      exp_q.delete();
      len_q.delete();
      m_cnt   = 0;
      m_early = 1'b0;
      m_miss  = 1'b0;
      m_unexp = 1'b0;
    end else begin
      sz  = exp_q.size();
      lsz = len_q.size();
      chk("m_rvalid",  64'(bus.m_rvalid), 64'(sz > 0));
      chk("s_rready",  64'(bus.s_rready), 64'(sz < DEPTH));
      chk("ar_ready",  64'(bus.ar_ready), 64'(lsz < OUTST));
      chk("err_early", 64'(err_early),    64'(m_early));
      chk("err_miss",  64'(err_miss),     64'(m_miss));
      chk("err_unexp", 64'(err_unexp),    64'(m_unexp));
      chk("beat_cnt",  64'(beat_cnt),     64'(m_cnt));
      if (sz > 0) begin
        chk("m_rdata", bus.m_rdata,      exp_q[0].data);
        chk("m_rid",   64'(bus.m_rid),   64'(exp_q[0].id));
        chk("m_rresp", 64'(bus.m_rresp), 64'(exp_q[0].resp));
        chk("m_rlast", 64'(bus.m_rlast), 64'(exp_q[0].last));
        if (bus.m_rready) begin
          void'(exp_q.pop_front());
        end
      end
      e_early = 1'b0;
      e_miss  = 1'b0;
      e_unexp = 1'b0;
      if (bus.s_rvalid && (sz < DEPTH)) begin
        b.id   = bus.s_rid;
        b.data = bus.s_rdata;
        b.resp = bus.s_rresp;
        b.last = bus.s_rlast;
        exp_q.push_back(b);
        if (lsz == 0) begin
          e_unexp = 1'b1;
        end else begin
          // Burst of len+1 beats: this is beat number m_cnt+1.
          len = len_q[0];
          if (m_cnt + 1 == len + 1) begin
            if (!bus.s_rlast) e_miss = 1'b1;
            void'(len_q.pop_front());
            m_cnt = 0;
          end else if (bus.s_rlast) begin
            e_early = 1'b1;
            void'(len_q.pop_front());
            m_cnt = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      if (bus.ar_valid && (lsz < OUTST)) begin
        len_q.push_back(int'(bus.ar_len));
      end
      if (err_clr) begin
        m_early = 1'b0;
        m_miss  = 1'b0;
        m_unexp = 1'b0;
      end else begin
        m_early = m_early | e_early;
        m_miss  = m_miss  | e_miss;
        m_unexp = m_unexp | e_unexp;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_ar(input int len);
    int n;
    n = 0;
    bus.ar_valid = 1'b1;
    bus.ar_len   = LEN_W'(len);
    while (!bus.ar_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL ar_timeout: got ar_ready=0 expected 1 within 50 cycles");
    end
    step();
    bus.ar_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
    int n;
    n = 0;
    bus.s_rvalid = 1'b1;
    bus.s_rid    = ID_W'($urandom_range(0, 1));
    bus.s_rdata  = d;
    bus.s_rresp  = r;
    bus.s_rlast  = l;
    while (!bus.s_rready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL beat_timeout: got s_rready=0 expected 1 within 50 cycles");
    end
    step();
    bus.s_rvalid = 1'b0;
  endtask

  initial begin
    resp_tab[0] = RESP_OKAY;
    resp_tab[1] = RESP_EXOKAY;
    resp_tab[2] = RESP_SLVERR;
    resp_tab[3] = RESP_DECERR;

    rst_n        = 1'b0;
    err_clr      = 1'b0;
    bus.ar_valid = 1'b0;
    bus.ar_len   = '0;
    bus.s_rvalid = 1'b0;
    bus.s_rid    = '0;
    bus.s_rdata  = '0;
    bus.s_rresp  = 2'b00;
    bus.s_rlast  = 1'b0;
    bus.m_rready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk("reset_m_rdata", bus.m_rdata, 64'h0);

    // 1: well-formed 4-beat burst, sink always ready
    bus.m_rready = 1'b1;
    drive_ar(3);
    for (int i = 0; i < 4; i++) drive_beat({$urandom, $urandom}, RESP_OKAY, 1'(i == 3));
    idle(3);

    // 2: fill the FIFO with the sink stalled, then release a single pop
    bus.m_rready = 1'b0;
    drive_ar(4);
    for (int i = 0; i < 4; i++) drive_beat({$urandom, $urandom}, RESP_EXOKAY, 1'b0);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 64'h0123_4567_89AB_CDEF;
    bus.s_rlast  = 1'b1;
    idle(2);
    bus.m_rready = 1'b1;
    step();
    bus.m_rready = 1'b0;
    step();
    bus.s_rvalid = 1'b0;
    bus.m_rready = 1'b1;
    idle(6);

    // 3: RLAST on beat 2 of a 4-beat burst, then clear
    drive_ar(3);
    drive_beat({$urandom, $urandom}, RESP_OKAY, 1'b0);
    drive_beat({$urandom, $urandom}, RESP_OKAY, 1'b1);
    idle(2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    idle(2);

    // 4: missing RLAST on a 2-beat burst, then a clean single-beat burst
    drive_ar(1);
    drive_beat({$urandom, $urandom}, RESP_OKAY, 1'b0);
    drive_beat({$urandom, $urandom}, RESP_OKAY, 1'b0);
    drive_ar(0);
    drive_beat({$urandom, $urandom}, RESP_OKAY, 1'b1);
    idle(2);

    // 5: beat with no burst outstanding
    drive_beat(64'hDEADBEEF_0BADF00D, RESP_SLVERR, 1'b1);
    idle(3);

    // 6: asynchronous reset with two beats buffered
    bus.m_rready = 1'b0;
    drive_ar(3);
    drive_beat({$urandom, $urandom}, RESP_OKAY, 1'b0);
    drive_beat({$urandom, $urandom}, RESP_OKAY, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_m_rvalid",  64'(bus.m_rvalid), 64'h0);
    chk("async_err_early", 64'(err_early),    64'h0);
    chk("async_err_miss",  64'(err_miss),     64'h0);
    chk("async_err_unexp", 64'(err_unexp),    64'h0);
    chk("async_beat_cnt",  64'(beat_cnt),     64'h0);
    chk("async_s_rready",  64'(bus.s_rready), 64'h1);
    chk("async_m_rdata",   bus.m_rdata,       64'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.ar_valid = ($urandom_range(0, 9) < 3);
      bus.ar_len   = LEN_W'($urandom_range(0, 3));
      bus.s_rvalid = ($urandom_range(0, 9) < 6);
      bus.s_rid    = ID_W'($urandom_range(0, 1));
      bus.s_rdata  = {$urandom, $urandom};
      bus.s_rresp  = resp_tab[$urandom_range(0, 3)];
      bus.s_rlast  = ($urandom_range(0, 9) < 3);
      bus.m_rready = ($urandom_range(0, 9) < 7);
      err_clr      = ($urandom_range(0, 99) < 3);
      step();
    end
    bus.ar_valid = 1'b0;
    bus.s_rvalid = 1'b0;
    err_clr      = 1'b0;
    bus.m_rready = 1'b1;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
